// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller at the ID/EX boundary of the 5-stage RV32IM pipeline:
// load-use stall, MEM/WB->EX forwarding, MUL/DIV busy stall and a saturating stall counter.
module hazard_forward_ctrl #(
  parameter int unsigned AW          = 5,
  parameter int unsigned LOAD_STALL  = 1,
  parameter int unsigned MD_STALL_EN = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [AW-1:0]    ex_rs1,
  input  logic [AW-1:0]    ex_rs2,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_mem_read,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_reg_write,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_reg_write,
  input  logic             md_start,
  input  logic             md_done,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             bubble_ex,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned CW = $clog2(LOAD_STALL + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] MD_BUSY   = 2'd2;

  logic [1:0]       state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [CNT_W-1:0] count_q;
  logic             lu;
  logic             md_hit;

  // MEM beats WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                         input logic [AW-1:0] m_rd, input logic m_we,
                                         input logic [AW-1:0] w_rd, input logic w_we);
    if (m_we && (m_rd != '0) && (m_rd == rs))      return 2'b01;
    else if (w_we && (w_rd != '0) && (w_rd == rs)) return 2'b10;
    else                                           return 2'b00;
  endfunction

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  assign md_hit = (MD_STALL_EN != 0) && md_start && !md_done;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    bubble_ex   = 1'b0;
    fwd_rs1_sel = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_rs2_sel = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    case (state)
      IDLE: begin
        if (md_hit) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          state_next  = MD_BUSY;
        end else if (lu) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          bubble_ex   = 1'b1;
          if (LOAD_STALL > 1) begin
            state_next = LOAD_WAIT;
            cnt_next   = CW'(LOAD_STALL - 1);
          end
        end
      end
      LOAD_WAIT: begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
        cnt_next    = cnt - CW'(1);
        if (cnt == CW'(1)) state_next = IDLE;
      end
      MD_BUSY: begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        stall_id_ex = 1'b1;
        if (md_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset masks every output in the same cycle.
    if (reset) begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      stall_id_ex = 1'b0;
      bubble_ex   = 1'b0;
      fwd_rs1_sel = 2'b00;
      fwd_rs2_sel = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      count_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stall_pc && (count_q != '1)) count_q <= count_q + CNT_W'(1);
    end
  end

  assign stall_count = reset ? '0 : count_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: three instances (LOAD_STALL=1, LOAD_STALL=3,
// CNT_W=2) share one stimulus bus; expectations are queued and checked on the falling edge.
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       md_start, md_done;

  logic [1:0]  f1_0, f2_0, f1_1, f2_1, f1_2, f2_2;
  logic        sp0, si0, se0, bx0, sp1, si1, se1, bx1, sp2, si2, se2, bx2;
  logic [15:0] c0, c1;
  logic [1:0]  c2;

  hazard_forward_ctrl #(.AW(5), .LOAD_STALL(1), .MD_STALL_EN(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .md_start(md_start), .md_done(md_done),
    .fwd_rs1_sel(f1_0), .fwd_rs2_sel(f2_0), .stall_pc(sp0), .stall_if_id(si0),
    .stall_id_ex(se0), .bubble_ex(bx0), .stall_count(c0));

  hazard_forward_ctrl #(.AW(5), .LOAD_STALL(3), .MD_STALL_EN(1), .CNT_W(16)) u_ls3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .md_start(md_start), .md_done(md_done),
    .fwd_rs1_sel(f1_1), .fwd_rs2_sel(f2_1), .stall_pc(sp1), .stall_if_id(si1),
    .stall_id_ex(se1), .bubble_ex(bx1), .stall_count(c1));

  hazard_forward_ctrl #(.AW(5), .LOAD_STALL(1), .MD_STALL_EN(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .md_start(md_start), .md_done(md_done),
    .fwd_rs1_sel(f1_2), .fwd_rs2_sel(f2_2), .stall_pc(sp2), .stall_if_id(si2),
    .stall_id_ex(se2), .bubble_ex(bx2), .stall_count(c2));

  // o = {fwd_rs1_sel, fwd_rs2_sel, stall_pc, stall_if_id, stall_id_ex, bubble_ex}
  typedef struct {
    string       name;
    int          dut;
    logic [7:0]  o;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  localparam logic [3:0] NO_STALL = 4'b0000;
  localparam logic [3:0] LD_STALL = 4'b1101;
  localparam logic [3:0] MD_STALL = 4'b1110;

  // Monitor: drain expectations issued this cycle against live outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [7:0]  got_o;
      int unsigned got_c;
      e = q.pop_front();
      case (e.dut)
        0:       begin got_o = {f1_0, f2_0, sp0, si0, se0, bx0}; got_c = 32'(c0); end
        1:       begin got_o = {f1_1, f2_1, sp1, si1, se1, bx1}; got_c = 32'(c1); end
        default: begin got_o = {f1_2, f2_2, sp2, si2, se2, bx2}; got_c = 32'(c2); end
      endcase
      tests++;
      if (got_o !== e.o || got_c != e.cnt) begin
        failed++;
        $display("FAIL %s (dut%0d): got fwd/stall=%b count=%0d, expected fwd/stall=%b count=%0d",
                 e.name, e.dut, got_o, got_c, e.o, e.cnt);
      end
    end
  end

  task automatic expect_out(input string name, input int dut, input logic [1:0] f1,
                            input logic [1:0] f2, input logic [3:0] st, input int unsigned cnt);
    exp_t e;
    e.name = name; e.dut = dut; e.o = {f1, f2, st}; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    md_start = 1'b0; md_done = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  // Reset with a live hazard and live forwarding: every output must read 0.
  task automatic do_reset();
    reset = 1'b1;
    set_load_use();
    mem_rd = 5'd9; mem_reg_write = 1'b1; ex_rs1 = 5'd9;
    for (int d = 0; d < 3; d++) expect_out("reset_outputs", d, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    do_reset();

    // 1) single-cycle load-use stall
    set_load_use();
    expect_out("lu_ls1_stall", 0, 2'b00, 2'b00, LD_STALL, 0);
    tick();
    clear_inputs();
    expect_out("lu_ls1_release", 0, 2'b00, 2'b00, NO_STALL, 1);
    tick();

    // 2) no hazard on x0 or unused operand
    do_reset();
    set_load_use(); ex_rd = 5'd0; id_rs1 = 5'd0;
    expect_out("lu_x0_no_stall", 0, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    set_load_use(); id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
    expect_out("lu_unused_no_stall", 0, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    id_use_rs2 = 1'b1;
    expect_out("lu_rs2_stall", 0, 2'b00, 2'b00, LD_STALL, 0);
    tick();
    clear_inputs();
    expect_out("lu_rs2_count", 0, 2'b00, 2'b00, NO_STALL, 1);
    tick();

    // 3) LOAD_STALL=3 with hazard held through the wait
    do_reset();
    set_load_use();
    for (int i = 0; i < 3; i++) begin
      expect_out("lu_ls3_stall", 1, 2'b00, 2'b00, LD_STALL, i);
      tick();
    end
    clear_inputs();
    expect_out("lu_ls3_idle", 1, 2'b00, 2'b00, NO_STALL, 3);
    tick();

    // 4) forwarding priority and x0
    do_reset();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs2 = 5'd7;
    expect_out("fwd_mem_prio", 0, 2'b00, 2'b01, NO_STALL, 0);
    tick();
    mem_reg_write = 1'b0;
    expect_out("fwd_wb", 0, 2'b00, 2'b10, NO_STALL, 0);
    tick();
    ex_rs2 = 5'd0;
    expect_out("fwd_none", 0, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1; ex_rs1 = 5'd0;
    expect_out("fwd_x0", 0, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    mem_rd = 5'd3; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd3;
    expect_out("fwd_both", 0, 2'b10, 2'b01, NO_STALL, 0);
    tick();
    clear_inputs();

    // 5) MUL/DIV busy for 34 cycles with a coincident load-use
    md_start = 1'b1; md_done = 1'b1;
    expect_out("md_same_cycle_done", 0, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    md_done = 1'b0;
    set_load_use();
    for (int i = 0; i < 34; i++) begin
      md_done = (i == 33);
      expect_out("md_busy", 0, 2'b00, 2'b00, MD_STALL, i);
      tick();
      md_start = 1'b0;
    end
    clear_inputs();
    expect_out("md_release", 0, 2'b00, 2'b00, NO_STALL, 34);
    tick();

    // 6a) reset during LOAD_WAIT
    do_reset();
    set_load_use();
    expect_out("rst_mid_first", 1, 2'b00, 2'b00, LD_STALL, 0);
    tick();
    reset = 1'b1;
    expect_out("rst_mid_forced", 1, 2'b00, 2'b00, NO_STALL, 0);
    tick();
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      expect_out("rst_mid_no_residue", 1, 2'b00, 2'b00, NO_STALL, 0);
      tick();
    end

    // 6b) CNT_W=2 saturates at 3
    do_reset();
    set_load_use();
    for (int i = 0; i < 5; i++) begin
      expect_out("sat_stall", 2, 2'b00, 2'b00, LD_STALL, (i > 3) ? 3 : i);
      tick();
    end
    clear_inputs();
    expect_out("sat_hold", 2, 2'b00, 2'b00, NO_STALL, 3);
    tick();

    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
